// File: rtl/sap1_pkg.sv
// Shared constants for the SAP-1 control sequencer: opcodes, one-hot T-state codes,
// control-word bit positions and the all-inactive control word.
package sap1_pkg;

    localparam int OPC_WIDTH = 4;

    localparam logic [3:0] OPC_LDA = 4'h0;
    localparam logic [3:0] OPC_ADD = 4'h1;
    localparam logic [3:0] OPC_SUB = 4'h2;
    localparam logic [3:0] OPC_OUT = 4'hE;
    localparam logic [3:0] OPC_HLT = 4'hF;

    localparam logic [5:0] T_NONE = 6'b000000;
    localparam logic [5:0] T1     = 6'b000001;
    localparam logic [5:0] T2     = 6'b000010;
    localparam logic [5:0] T3     = 6'b000100;
    localparam logic [5:0] T4     = 6'b001000;
    localparam logic [5:0] T5     = 6'b010000;
    localparam logic [5:0] T6     = 6'b100000;

    localparam int CW_WIDTH = 12;
    localparam int CW_CP    = 11;
    localparam int CW_EP    = 10;
    localparam int CW_N_LM  = 9;
    localparam int CW_N_CE  = 8;
    localparam int CW_N_LI  = 7;
    localparam int CW_EI    = 6;
    localparam int CW_N_LA  = 5;
    localparam int CW_EA    = 4;
    localparam int CW_SU    = 3;
    localparam int CW_EU    = 2;
    localparam int CW_N_LB  = 1;
    localparam int CW_N_LO  = 0;

    // Active-low loads/enables sit at 1, everything else at 0.
    localparam logic [CW_WIDTH-1:0] CW_INACTIVE = 12'h3A3;

    // Bus drivers of a control word, normalised to active-high.
    function automatic logic [4:0] bus_drivers(input logic [CW_WIDTH-1:0] cw);
        return {cw[CW_EP], ~cw[CW_N_CE], cw[CW_EI], cw[CW_EA], cw[CW_EU]};
    endfunction

endpackage

// File: rtl/sap1_bus_checker.sv
// Runtime checks for the controller: never more than one bus driver, and a T-state that is
// one-hot or zero.
module sap1_bus_checker
    import sap1_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic [CW_WIDTH-1:0] cw,
    input  logic [5:0]          t_state
);

    a_single_bus_driver: assert property (@(posedge clock) disable iff (reset)
        $onehot0(bus_drivers(cw)));

    a_t_state_onehot0: assert property (@(posedge clock) disable iff (reset)
        $onehot0(t_state));

endmodule

// File: rtl/sap1_ring_counter.sv
// One-hot T1..T6 ring with a terminal HALT state; reset parks the ring in T1.
// Outputs read zero while reset is asserted or once halted.
module sap1_ring_counter
    import sap1_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       run,
    input  logic       restart,
    input  logic       halt,
    output logic [5:0] t_state,
    output logic       halted
);

    logic [5:0] t_d;
    logic [5:0] t_q;
    logic       halted_d;
    logic       halted_q;

    // Next-state: advance only when running, jump to T1 on restart, leave the ring on halt.
    always_comb begin
        t_d      = t_q;
        halted_d = halted_q;
        if (halted_q) begin
            t_d = T_NONE;
        end else if (run) begin
            if (halt) begin
                t_d      = T_NONE;
                halted_d = 1'b1;
            end else if (restart) begin
                t_d = T1;
            end else begin
                case (t_q)
                    T1:      t_d = T2;
                    T2:      t_d = T3;
                    T3:      t_d = T4;
                    T4:      t_d = T5;
                    T5:      t_d = T6;
                    T6:      t_d = T1;
                    default: t_d = T1;
                endcase
            end
        end else begin
            t_d = t_q;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            t_q      <= T1;
            halted_q <= 1'b0;
        end else begin
            t_q      <= t_d;
            halted_q <= halted_d;
        end
    end

    assign t_state = (reset || halted_q) ? T_NONE : t_q;
    assign halted  = ~reset & halted_q;

endmodule

// File: rtl/sap1_controller.sv
// SAP-1 control sequencer: T-state ring plus Moore decode of (T-state, opcode) into the control word.
// Optional build macro SAP1_EARLY_RETURN_EN returns the ring to T1 right after an instruction's last active T-state.
module sap1_controller
    import sap1_pkg::*;
#(
    parameter int                  OP_WIDTH = OPC_WIDTH,
    parameter logic [OP_WIDTH-1:0] OP_LDA   = OPC_LDA,
    parameter logic [OP_WIDTH-1:0] OP_ADD   = OPC_ADD,
    parameter logic [OP_WIDTH-1:0] OP_SUB   = OPC_SUB,
    parameter logic [OP_WIDTH-1:0] OP_OUT   = OPC_OUT,
    parameter logic [OP_WIDTH-1:0] OP_HLT   = OPC_HLT
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                run,
    input  logic [OP_WIDTH-1:0] opcode,
    output logic                cp,
    output logic                ep,
    output logic                n_lm,
    output logic                n_ce,
    output logic                n_li,
    output logic                ei,
    output logic                n_la,
    output logic                ea,
    output logic                su,
    output logic                eu,
    output logic                n_lb,
    output logic                n_lo,
    output logic [5:0]          t_state,
    output logic                halted
);

    logic [CW_WIDTH-1:0] cw_s;
    logic                restart_s;
    logic                halt_s;
    logic                known_op_s;

    assign known_op_s = (opcode == OP_LDA) || (opcode == OP_ADD) || (opcode == OP_SUB) ||
                        (opcode == OP_OUT) || (opcode == OP_HLT);
    assign halt_s     = (t_state == T4) && (opcode == OP_HLT);

    sap1_ring_counter u_ring (
        .clock   (clock),
        .reset   (reset),
        .run     (run),
        .restart (restart_s),
        .halt    (halt_s),
        .t_state (t_state),
        .halted  (halted)
    );

`ifdef SAP1_EARLY_RETURN_EN
    // Early return: the opcode decides after which T-state the ring goes back to T1.
    always_comb begin
        restart_s = 1'b0;
        case (t_state)
            T3:      restart_s = ~known_op_s;
            T4:      restart_s = (opcode == OP_OUT);
            T5:      restart_s = (opcode == OP_LDA);
            default: restart_s = 1'b0;
        endcase
    end
`else
    // Fixed six T-states per instruction.
    always_comb begin
        restart_s = 1'b0;
    end
`endif

    // Control-word decode; t_state already reads zero in reset and HALT, and run=0 blanks it.
    always_comb begin
        cw_s = CW_INACTIVE;
        if (run) begin
            case (t_state)
                T1: begin
                    cw_s[CW_EP]   = 1'b1;
                    cw_s[CW_N_LM] = 1'b0;
                end
                T2: begin
                    cw_s[CW_CP] = 1'b1;
                end
                T3: begin
                    cw_s[CW_N_CE] = 1'b0;
                    cw_s[CW_N_LI] = 1'b0;
                end
                T4: begin
                    if ((opcode == OP_LDA) || (opcode == OP_ADD) || (opcode == OP_SUB)) begin
                        cw_s[CW_EI]   = 1'b1;
                        cw_s[CW_N_LM] = 1'b0;
                    end else if (opcode == OP_OUT) begin
                        cw_s[CW_EA]   = 1'b1;
                        cw_s[CW_N_LO] = 1'b0;
                    end else begin
                        cw_s = CW_INACTIVE;
                    end
                end
                T5: begin
                    if (opcode == OP_LDA) begin
                        cw_s[CW_N_CE] = 1'b0;
                        cw_s[CW_N_LA] = 1'b0;
                    end else if ((opcode == OP_ADD) || (opcode == OP_SUB)) begin
                        cw_s[CW_N_CE] = 1'b0;
                        cw_s[CW_N_LB] = 1'b0;
                    end else begin
                        cw_s = CW_INACTIVE;
                    end
                end
                T6: begin
                    if ((opcode == OP_ADD) || (opcode == OP_SUB)) begin
                        cw_s[CW_EU]   = 1'b1;
                        cw_s[CW_N_LA] = 1'b0;
                        cw_s[CW_SU]   = (opcode == OP_SUB);
                    end else begin
                        cw_s = CW_INACTIVE;
                    end
                end
                default: cw_s = CW_INACTIVE;
            endcase
        end else begin
            cw_s = CW_INACTIVE;
        end
    end

    assign cp   = cw_s[CW_CP];
    assign ep   = cw_s[CW_EP];
    assign n_lm = cw_s[CW_N_LM];
    assign n_ce = cw_s[CW_N_CE];
    assign n_li = cw_s[CW_N_LI];
    assign ei   = cw_s[CW_EI];
    assign n_la = cw_s[CW_N_LA];
    assign ea   = cw_s[CW_EA];
    assign su   = cw_s[CW_SU];
    assign eu   = cw_s[CW_EU];
    assign n_lb = cw_s[CW_N_LB];
    assign n_lo = cw_s[CW_N_LO];

    sap1_bus_checker u_checker (
        .clock   (clock),
        .reset   (reset),
        .cw      (cw_s),
        .t_state (t_state)
    );

endmodule
